conv1x1_sched: RTL

Sequencer that streams a frame of 8-bit colour pixels from a synchronous read memory through the combinational 1x1 convolution unit (int-to-float, FP multiply by a 32-bit IEEE-754 weight, float-to-int) and writes the results to an output memory. It sits between the frame buffers and the convolution unit. It issues one pixel per cycle, pipelines the memory and datapath latency, and signals completion. The convolution unit is instantiated outside this block and connected through the `conv_*` ports.

---
 rtl/conv_pkg.sv | 6 +
 rtl/conv1x1_pipe.sv | 43 ++++
 rtl/conv1x1_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and pipeline constants for conv1x1_sched
package conv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  localparam int CONV_PIPE_DEPTH = 3;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
endpackage

// File: rtl/conv1x1_pipe.sv
// conv1x1_pipe: valid/address/data shift pipe from read port to write port
module conv1x1_pipe
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_rd_data,
  input  logic [7:0]            i_conv_out,
  output logic [7:0]            o_conv_in,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_inflight
);
  logic [CONV_PIPE_DEPTH-1:0] r_v;
  logic [ADDR_WIDTH-1:0]      r_a [CONV_PIPE_DEPTH];
  logic [7:0]                 r_conv_in;
  logic [7:0]                 r_wr_data;
  // shift valid and write address; capture memory data then convolution result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v       <= '0;
      for (int i = 0; i < CONV_PIPE_DEPTH; i++) r_a[i] <= '0;
      r_conv_in <= '0;
      r_wr_data <= '0;
    end else begin
      r_v    <= {r_v[CONV_PIPE_DEPTH-2:0], i_valid};
      r_a[0] <= i_addr;
      for (int i = 1; i < CONV_PIPE_DEPTH; i++) r_a[i] <= r_a[i-1];
      if (r_v[0]) r_conv_in <= i_rd_data;
      if (r_v[1]) r_wr_data <= i_conv_out;
    end
  end
  assign o_conv_in  = r_conv_in;
  assign o_wr_en    = r_v[CONV_PIPE_DEPTH-1];
  assign o_wr_addr  = r_a[CONV_PIPE_DEPTH-1];
  assign o_wr_data  = r_wr_data;
  assign o_inflight = |r_v[CONV_PIPE_DEPTH-2:0];
endmodule

// File: rtl/conv1x1_sched.sv
// conv1x1_sched: streams a pixel frame through the 1x1 conv unit; CONV1X1_SCHED_PERF_CNT_EN adds perf_cycles
module conv1x1_sched
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   num_pix,
  input  logic [ADDR_WIDTH-1:0]   rd_base,
  input  logic [ADDR_WIDTH-1:0]   wr_base,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [7:0]              rd_data,
  output logic [7:0]              conv_data_in,
  output logic [WEIGHT_WIDTH-1:0] conv_weight,
  input  logic [7:0]              conv_data_out,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy,
  output logic                    done
`ifdef CONV1X1_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);
  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_num, r_rd_base, r_wr_base, r_k;
  logic [WEIGHT_WIDTH-1:0] r_weight;
  logic                    w_accept, w_last, w_inflight;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = r_k == r_num - 1'b1;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next-state: a zero-length frame skips straight to the completion pulse
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? ((num_pix == '0) ? S_DONE : S_ISSUE) : S_IDLE;
      S_ISSUE: w_next = w_last ? S_DRAIN : S_ISSUE;
      S_DRAIN: w_next = w_inflight ? S_DRAIN : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // run parameters are frozen at start; issue counter advances once per read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= '0;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_weight  <= '0;
      r_k       <= '0;
    end else if (w_accept) begin
      r_num     <= num_pix;
      r_rd_base <= rd_base;
      r_wr_base <= wr_base;
      r_weight  <= weight;
      r_k       <= '0;
    end else if (r_state == S_ISSUE) begin
      r_k <= r_k + 1'b1;
    end
  end
  assign rd_en       = r_state == S_ISSUE;
  assign rd_addr     = rd_en ? r_rd_base + r_k : '0;
  assign conv_weight = r_weight;
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_DONE;
  conv1x1_pipe #(.ADDR_WIDTH(ADDR_WIDTH)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (rd_en),
    .i_addr    (r_wr_base + r_k),
    .i_rd_data (rd_data),
    .i_conv_out(conv_data_out),
    .o_conv_in (conv_data_in),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_inflight(w_inflight)
  );
`ifdef CONV1X1_SCHED_PERF_CNT_EN
  logic [31:0] r_perf;
  // count busy cycles, saturating, holding the last run's total while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_perf <= '0;
    else if (w_accept)                r_perf <= '0;
    else if (busy && r_perf != '1)    r_perf <= r_perf + 1'b1;
  end
  assign perf_cycles = r_perf;
`endif
endmodule
